// File: rtl/prra_pkg.sv
// Shared types and helpers for the prra arbiter and its packet multiplexer.
package prra_pkg;

  typedef enum logic [1:0] {
    ARBITRATE = 2'd0,
    XFER      = 2'd1,
    RELEASE   = 2'd2
  } mux_state_e;

  localparam int unsigned ONEHOT_MAX_W = 32;

  // True when exactly one bit is set; narrower vectors are zero-extended by the caller.
  function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/prra_pkt_mux_sel.sv
// Grant consistency check and lock-indexed selection of the source beat.
module prra_pkt_mux_sel
  import prra_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOG2_WIDTH = $clog2(WIDTH),
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [WIDTH-1:0]            in_valid,
  input  logic [WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0]            in_last,
  input  logic [LOG2_WIDTH-1:0]       lock,
  input  logic [LOG2_WIDTH-1:0]       arb_state,
  input  logic [WIDTH-1:0]            arb_grant,
  output logic                        grant_ok_c,
  output logic                        sel_valid_c,
  output logic                        sel_last_c,
  output logic [DATA_WIDTH-1:0]       sel_data_c
);

  logic state_valid;

  always_comb begin
    sel_valid_c = 1'b0;
    sel_last_c  = 1'b0;
    sel_data_c  = '0;
    state_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lock == LOG2_WIDTH'(i)) begin
        sel_valid_c = in_valid[i];
        sel_last_c  = in_last[i];
        sel_data_c  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (arb_state == LOG2_WIDTH'(i)) begin
        state_valid = in_valid[i];
      end
    end
    // Grant is usable only if one-hot, agreeing with arb_state, and that source still wants it.
    grant_ok_c = is_onehot(ONEHOT_MAX_W'(arb_grant))
               && (arb_grant == (WIDTH'(1) << arb_state))
               && state_valid;
  end

endmodule

// File: rtl/prra_pkt_mux.sv
// N-to-1 packet multiplexer driven by the prra arbiter: locks the granted source
// until end-of-packet and forwards beats through a registered valid/ready output.
module prra_pkt_mux
  import prra_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned LOG2_WIDTH  = $clog2(WIDTH),
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ARB_LATENCY = 3
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic [WIDTH-1:0]            in_valid,
  input  logic [WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0]            in_last,
  output logic [WIDTH-1:0]            in_ready,
  output logic [WIDTH-1:0]            arb_request,
  input  logic [LOG2_WIDTH-1:0]       arb_state,
  input  logic [WIDTH-1:0]            arb_grant,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_last,
  output logic [LOG2_WIDTH-1:0]       out_src,
  input  logic                        out_ready
);

  localparam int unsigned CNT_W = (ARB_LATENCY < 1) ? 1 : $clog2(ARB_LATENCY + 1);

  mux_state_e              state_q, state_d;
  logic [LOG2_WIDTH-1:0]   lock_q, lock_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        arb_request_d;
  logic [WIDTH-1:0]        lock_mask;
  logic                    out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_d;
  logic                    out_last_d;
  logic [LOG2_WIDTH-1:0]   out_src_d;
  logic                    out_free;
  logic                    beat_acc;

  logic                    grant_ok_c;
  logic                    sel_valid_c;
  logic                    sel_last_c;
  logic [DATA_WIDTH-1:0]   sel_data_c;

  prra_pkt_mux_sel #(
    .WIDTH      (WIDTH),
    .LOG2_WIDTH (LOG2_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sel (
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .lock        (lock_q),
    .arb_state   (arb_state),
    .arb_grant   (arb_grant),
    .grant_ok_c  (grant_ok_c),
    .sel_valid_c (sel_valid_c),
    .sel_last_c  (sel_last_c),
    .sel_data_c  (sel_data_c)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ARBITRATE;
      lock_q      <= '0;
      cnt_q       <= '0;
      arb_request <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_src     <= '0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      cnt_q       <= cnt_d;
      arb_request <= arb_request_d;
      out_valid   <= out_valid_d;
      out_data    <= out_data_d;
      out_last    <= out_last_d;
      out_src     <= out_src_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    cnt_d       = cnt_q;
    in_ready    = '0;
    beat_acc    = 1'b0;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_last_d  = out_last;
    out_src_d   = out_src;
    out_free    = !out_valid || out_ready;

    case (state_q)
      ARBITRATE: begin
        if (grant_ok_c) begin
          lock_d  = arb_state;
          state_d = XFER;
        end
      end
      XFER: begin
        if (sel_valid_c && out_free && !srst) begin
          in_ready = WIDTH'(1) << lock_q;
          beat_acc = 1'b1;
        end
        if (beat_acc && sel_last_c) begin
          state_d = RELEASE;
          cnt_d   = CNT_W'(ARB_LATENCY);
        end
      end
      RELEASE: begin
        // Wait out the arbiter's stale grant before listening to it again.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ARBITRATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ARBITRATE;
    endcase

    if (beat_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data_c;
      out_last_d  = sel_last_c;
      out_src_d   = lock_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Request is registered against the next state so it tracks lock/release edges exactly.
    lock_mask = WIDTH'(1) << lock_d;
    case (state_d)
      XFER:    arb_request_d = in_valid | lock_mask;
      RELEASE: arb_request_d = in_valid & ~lock_mask;
      default: arb_request_d = in_valid;
    endcase
  end

endmodule
